// File: rtl/contador_pkg.sv
// Shared constants for the counter control front-end: default timing,
// direction levels and mode encodings.
package contador_pkg;

  localparam int unsigned DB_CYCLES_DEF = 500000;
  localparam int unsigned TICK_DIV_DEF  = 50000000;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

endpackage

// File: rtl/debounce_pulse.sv
// Synchronizes and debounces one raw pushbutton, producing its clean level
// and a registered single-cycle pulse on each accepted press.
module debounce_pulse
  import contador_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(DB_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic [1:0]    r_vld;
  logic          r_armed;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_pulse;
  logic          w_diff;
  logic          w_flip;

  assign w_diff = (r_sync2 != r_level);
  assign w_flip = w_diff && (r_cnt == TERM);

  // A button still held across reset must be seen released before it may pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      r_vld   <= {r_vld[0], 1'b1};
      if (r_vld[1] && !r_sync2) begin
        r_armed <= 1'b1;
      end
      if (!w_diff || w_flip) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_flip) begin
        r_level <= r_sync2;
      end
      r_pulse <= w_flip && r_sync2 && r_armed;
    end
  end

  assign level = r_level;
  assign pulse = r_pulse;

endmodule

// File: rtl/contador_ctrl.sv
// Control front-end for the 4-bit up/down counter: turns raw buttons and
// switches into clean enable/load strobes and a held updown level.
module contador_ctrl
  import contador_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned TICK_DIV  = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_load,
  input  logic sw_auto,
  input  logic sw_dir,
  output logic enable,
  output logic updown,
  output logic load
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_TERM = PW'(TICK_DIV - 1);

  logic          w_up_pulse;
  logic          w_dn_pulse;
  logic          w_ld_pulse;
  logic          w_up_level;
  logic          w_dn_level;
  logic          w_ld_level;
  logic          w_unused_levels;

  logic          r_auto_s1;
  logic          r_auto_s2;
  logic          r_auto_q;
  logic          r_dir_s1;
  logic          r_dir_s2;
  logic [PW-1:0] r_presc;
  logic          r_enable;
  logic          r_updown;
  logic          r_load;

  logic [PW-1:0] w_presc_nxt;
  logic          w_enable_nxt;
  logic          w_updown_nxt;
  logic          w_mode_chg;
  mode_e         w_mode;

  debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .reset_n(reset_n), .raw(btn_up), .level(w_up_level), .pulse(w_up_pulse)
  );

  debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk(clk), .reset_n(reset_n), .raw(btn_down), .level(w_dn_level), .pulse(w_dn_pulse)
  );

  debounce_pulse #(.DB_CYCLES(DB_CYCLES)) u_db_load (
    .clk(clk), .reset_n(reset_n), .raw(btn_load), .level(w_ld_level), .pulse(w_ld_pulse)
  );

  assign w_unused_levels = w_up_level ^ w_dn_level ^ w_ld_level;

  assign w_mode     = mode_e'(r_auto_s2);
  assign w_mode_chg = (r_auto_s2 != r_auto_q);

  // Load and mode changes win over stepping and restart the prescaler.
  always_comb begin
    w_presc_nxt  = '0;
    w_enable_nxt = 1'b0;
    w_updown_nxt = r_updown;
    if (w_ld_pulse || w_mode_chg) begin
      w_presc_nxt = '0;
    end else if (w_mode == MODE_AUTO) begin
      if (r_presc == P_TERM) begin
        w_enable_nxt = 1'b1;
        w_updown_nxt = r_dir_s2 ? UP : DOWN;
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end else if (w_up_pulse != w_dn_pulse) begin
      w_enable_nxt = 1'b1;
      w_updown_nxt = w_up_pulse ? UP : DOWN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_auto_s1 <= 1'b0;
      r_auto_s2 <= 1'b0;
      r_auto_q  <= 1'b0;
      r_dir_s1  <= 1'b0;
      r_dir_s2  <= 1'b0;
      r_presc   <= '0;
      r_enable  <= 1'b0;
      r_updown  <= UP;
      r_load    <= 1'b0;
    end else begin
      r_auto_s1 <= sw_auto;
      r_auto_s2 <= r_auto_s1;
      r_auto_q  <= r_auto_s2;
      r_dir_s1  <= sw_dir;
      r_dir_s2  <= r_dir_s1;
      r_presc   <= w_presc_nxt;
      r_enable  <= w_enable_nxt;
      r_updown  <= w_updown_nxt;
      r_load    <= w_ld_pulse;
    end
  end

  assign enable = r_enable;
  assign updown = r_updown;
  assign load   = r_load;

endmodule

// File: tb/tb_contador_ctrl.sv
// Directed bench for contador_ctrl with short debounce/prescaler periods and
// a behavioural 4-bit counter driven from the strobes.
module tb_contador_ctrl;

  localparam int unsigned DB = 4;
  localparam int unsigned TD = 5;

  logic clk;
  logic reset_n;
  logic btn_up;
  logic btn_down;
  logic btn_load;
  logic sw_auto;
  logic sw_dir;
  logic enable;
  logic updown;
  logic load;

  int n_checks;
  int n_fail;

  logic [3:0] sb_din;
  logic [3:0] sb_cnt;
  int         sb_steps;

  contador_ctrl #(.DB_CYCLES(DB), .TICK_DIV(TD)) dut (
    .clk(clk), .reset_n(reset_n),
    .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
    .sw_auto(sw_auto), .sw_dir(sw_dir),
    .enable(enable), .updown(updown), .load(load)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 4-bit loadable up/down counter fed by the control outputs.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb_cnt   <= 4'd0;
      sb_steps <= 0;
    end else if (load) begin
      sb_cnt <= sb_din;
    end else if (enable) begin
      sb_cnt   <= updown ? sb_cnt + 4'd1 : sb_cnt - 4'd1;
      sb_steps <= sb_steps + 1;
    end
  end

  task automatic nclk(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic press(input int which);
    case (which)
      0: btn_up = 1'b1;
      1: btn_down = 1'b1;
      default: btn_load = 1'b1;
    endcase
    nclk(10);
    btn_up = 1'b0;
    btn_down = 1'b0;
    btn_load = 1'b0;
    nclk(10);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    btn_up = 1'b0; btn_down = 1'b0; btn_load = 1'b0;
    sw_auto = 1'b0; sw_dir = 1'b0; sb_din = 4'd0;
    @(negedge clk);
    n_checks += 3;
    if (enable !== 1'b0) begin n_fail++; $display("FAIL rst_enable got=%b exp=0", enable); end
    if (load !== 1'b0) begin n_fail++; $display("FAIL rst_load got=%b exp=0", load); end
    if (updown !== 1'b1) begin n_fail++; $display("FAIL rst_updown got=%b exp=1", updown); end
    nclk(2);
    reset_n = 1'b1;
    nclk(5);
    n_checks += 3;
    if (enable !== 1'b0) begin n_fail++; $display("FAIL idle_enable got=%b exp=0", enable); end
    if (load !== 1'b0) begin n_fail++; $display("FAIL idle_load got=%b exp=0", load); end
    if (updown !== 1'b1) begin n_fail++; $display("FAIL idle_updown got=%b exp=1", updown); end
  endtask

  task automatic test_press_latency;
    logic exp;
    btn_up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp = (i == 7);
      n_checks++;
      if (enable !== exp) begin n_fail++; $display("FAIL latency_en cyc=%0d got=%b exp=%b", i, enable, exp); end
      if (i == 7) begin
        n_checks++;
        if (updown !== 1'b1) begin n_fail++; $display("FAIL latency_ud got=%b exp=1", updown); end
      end
    end
    btn_up = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (enable !== 1'b0) begin n_fail++; $display("FAIL release_en cyc=%0d got=%b exp=0", i, enable); end
    end
  endtask

  task automatic test_bounce;
    logic exp;
    btn_down = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 3) btn_down = 1'b0;
      n_checks++;
      if (enable !== 1'b0) begin n_fail++; $display("FAIL bounce_en cyc=%0d got=%b exp=0", i, enable); end
    end
    btn_down = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp = (i == 7);
      n_checks++;
      if (enable !== exp) begin n_fail++; $display("FAIL down_en cyc=%0d got=%b exp=%b", i, enable, exp); end
      if (i == 7) begin
        n_checks++;
        if (updown !== 1'b0) begin n_fail++; $display("FAIL down_ud got=%b exp=0", updown); end
      end
    end
    btn_down = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (enable !== 1'b0) begin n_fail++; $display("FAIL down_rel_en cyc=%0d got=%b exp=0", i, enable); end
    end
  endtask

  task automatic test_auto;
    logic exp_en;
    logic exp_ud;
    sw_dir  = 1'b0;
    sw_auto = 1'b1;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      exp_en = (i >= 8) && (((i - 8) % 5) == 0);
      exp_ud = (i >= 28);
      n_checks++;
      if (enable !== exp_en) begin n_fail++; $display("FAIL auto_en cyc=%0d got=%b exp=%b", i, enable, exp_en); end
      if (exp_en) begin
        n_checks++;
        if (updown !== exp_ud) begin n_fail++; $display("FAIL auto_ud cyc=%0d got=%b exp=%b", i, updown, exp_ud); end
      end
      if (i == 10) btn_up = 1'b1;
      if (i == 20) btn_up = 1'b0;
      if (i == 24) sw_dir = 1'b1;
    end
  endtask

  task automatic test_load_priority;
    logic exp_en;
    logic exp_ld;
    for (int i = 36; i <= 55; i++) begin
      @(negedge clk);
      exp_en = (i == 38) || (i == 48) || (i == 53);
      exp_ld = (i == 43);
      n_checks += 2;
      if (enable !== exp_en) begin n_fail++; $display("FAIL ldprio_en cyc=%0d got=%b exp=%b", i, enable, exp_en); end
      if (load !== exp_ld) begin n_fail++; $display("FAIL ldprio_ld cyc=%0d got=%b exp=%b", i, load, exp_ld); end
      if (i == 36) btn_load = 1'b1;
      if (i == 46) btn_load = 1'b0;
    end
  endtask

  task automatic test_mode_change;
    sw_auto = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_checks++;
      if (enable !== 1'b0) begin n_fail++; $display("FAIL modechg_en cyc=%0d got=%b exp=0", i, enable); end
    end
  endtask

  task automatic test_simultaneous;
    btn_up = 1'b1;
    btn_down = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (enable !== 1'b0) begin n_fail++; $display("FAIL cancel_en cyc=%0d got=%b exp=0", i, enable); end
      if (updown !== 1'b1) begin n_fail++; $display("FAIL cancel_ud cyc=%0d got=%b exp=1", i, updown); end
    end
    btn_up = 1'b0;
    btn_down = 1'b0;
    nclk(12);
  endtask

  task automatic test_reset_mid_press;
    logic exp;
    btn_down = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      exp = (i == 7);
      n_checks++;
      if (enable !== exp) begin n_fail++; $display("FAIL pre_rst_en cyc=%0d got=%b exp=%b", i, enable, exp); end
    end
    n_checks++;
    if (updown !== 1'b0) begin n_fail++; $display("FAIL pre_rst_ud got=%b exp=0", updown); end
    reset_n = 1'b0;
    #1;
    n_checks += 3;
    if (enable !== 1'b0) begin n_fail++; $display("FAIL midrst_enable got=%b exp=0", enable); end
    if (load !== 1'b0) begin n_fail++; $display("FAIL midrst_load got=%b exp=0", load); end
    if (updown !== 1'b1) begin n_fail++; $display("FAIL midrst_updown got=%b exp=1", updown); end
    nclk(2);
    reset_n = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (enable !== 1'b0) begin n_fail++; $display("FAIL post_rst_en cyc=%0d got=%b exp=0", i, enable); end
    end
    btn_down = 1'b0;
    nclk(12);
    btn_down = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      exp = (i == 7);
      n_checks++;
      if (enable !== exp) begin n_fail++; $display("FAIL repress_en cyc=%0d got=%b exp=%b", i, enable, exp); end
    end
    btn_down = 1'b0;
    nclk(12);
  endtask

  task automatic test_scoreboard;
    int base;
    sb_din = 4'd9;
    press(2);
    n_checks++;
    if (sb_cnt !== 4'd9) begin n_fail++; $display("FAIL sb_load9 got=%0d exp=9", sb_cnt); end
    sb_din = 4'd0;
    press(2);
    n_checks++;
    if (sb_cnt !== 4'd0) begin n_fail++; $display("FAIL sb_load0 got=%0d exp=0", sb_cnt); end
    base = sb_steps;
    for (int k = 0; k < 17; k++) press(0);
    n_checks += 2;
    if (sb_cnt !== 4'd1) begin n_fail++; $display("FAIL sb_wrap got=%0d exp=1", sb_cnt); end
    if (sb_steps - base !== 17) begin n_fail++; $display("FAIL sb_steps got=%0d exp=17", sb_steps - base); end
    press(2);
    n_checks++;
    if (sb_cnt !== 4'd0) begin n_fail++; $display("FAIL sb_reload0 got=%0d exp=0", sb_cnt); end
    press(1);
    n_checks++;
    if (sb_cnt !== 4'd15) begin n_fail++; $display("FAIL sb_underflow got=%0d exp=15", sb_cnt); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_press_latency();
    test_bounce();
    test_auto();
    test_load_priority();
    test_mode_change();
    test_simultaneous();
    test_reset_mid_press();
    test_scoreboard();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
